bucket_update_unit: RTL and testbench

// - Stage directly after the forwarding stage: consumes the per-table corrected bucket content/valid and applies one op
//   (lookup/insert/delete) across all tables.
// - Emits a registered per-table write-back (adr/content/valid/update flag) to bucket memory; the same signals feed the

---
 rtl/hash_pkg.sv | 24 ++
 rtl/bucket_slot_match.sv | 41 ++++
 rtl/bucket_update_unit.sv | 167 ++++++++++++++++
 tb/tb_bucket_update_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - op/status encodings and entry width helper for the bucket update stage
package hash_pkg;

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2
   } op_t;

   typedef enum logic [2:0] {
      ST_MISS     = 3'd0,
      ST_HIT      = 3'd1,
      ST_INSERTED = 3'd2,
      ST_UPDATED  = 3'd3,
      ST_DELETED  = 3'd4,
      ST_FULL     = 3'd5,
      ST_BAD_OP   = 3'd6
   } status_t;

   function automatic int entry_width(input int key_width, input int data_width);
      return key_width + data_width;
   endfunction

endpackage

// File: rtl/bucket_slot_match.sv
// rtl/bucket_slot_match.sv - per-table key match and free-slot search over one bucket
module bucket_slot_match
   import hash_pkg::*;
#(
   parameter int KEY_WIDTH   = 2,
   parameter int DATA_WIDTH  = 4,
   parameter int BUCKET_SIZE = 1,
   localparam int E          = entry_width(KEY_WIDTH, DATA_WIDTH),
   localparam int SLOT_W     = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1
) (
   input  logic [KEY_WIDTH-1:0]     key,
   input  logic [E*BUCKET_SIZE-1:0] content,
   input  logic [BUCKET_SIZE-1:0]   valid,
   output logic                     hit,
   output logic [SLOT_W-1:0]        hit_slot,
   output logic                     free,
   output logic [SLOT_W-1:0]        free_slot,
   output logic [DATA_WIDTH-1:0]    hit_data
);

   // Walk from the highest slot down so the lowest matching slot wins.
   always_comb begin
      hit       = 1'b0;
      hit_slot  = '0;
      free      = 1'b0;
      free_slot = '0;
      hit_data  = '0;
      for (int s = BUCKET_SIZE - 1; s >= 0; s--) begin
         if (valid[s] && (content[s*E+DATA_WIDTH +: KEY_WIDTH] == key)) begin
            hit      = 1'b1;
            hit_slot = SLOT_W'(s);
            hit_data = content[s*E +: DATA_WIDTH];
         end
         if (!valid[s]) begin
            free      = 1'b1;
            free_slot = SLOT_W'(s);
         end
      end
   end

endmodule

// File: rtl/bucket_update_unit.sv
// rtl/bucket_update_unit.sv - applies lookup/insert/delete across all tables and registers write-back and result
module bucket_update_unit
   import hash_pkg::*;
#(
   parameter int DATA_WIDTH         = 4,
   parameter int KEY_WIDTH          = 2,
   parameter int NUMBER_OF_TABLES   = 4,
   parameter int BUCKET_SIZE        = 1,
   parameter int MAX_HASH_ADR_WIDTH = 2,
   localparam int E                 = entry_width(KEY_WIDTH, DATA_WIDTH),
   localparam int BW                = E * BUCKET_SIZE
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic                                                 clk_en,
   input  logic                                                 op_valid_i,
   output logic                                                 op_ready_o,
   input  logic [1:0]                                           op_i,
   input  logic [KEY_WIDTH-1:0]                                 key_i,
   input  logic [DATA_WIDTH-1:0]                                data_i,
   input  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]  hash_adr_i,
   input  logic [NUMBER_OF_TABLES-1:0][BW-1:0]                  content_i,
   input  logic [NUMBER_OF_TABLES-1:0][BUCKET_SIZE-1:0]         valid_i,
   output logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0]  wb_hash_adr_o,
   output logic [NUMBER_OF_TABLES-1:0][BW-1:0]                  wb_content_o,
   output logic [NUMBER_OF_TABLES-1:0][BUCKET_SIZE-1:0]         wb_valid_o,
   output logic [NUMBER_OF_TABLES-1:0]                          wb_updated_mem_o,
   output logic                                                 result_valid_o,
   input  logic                                                 result_ready_i,
   output logic [2:0]                                           result_status_o,
   output logic [DATA_WIDTH-1:0]                                result_data_o
);

   localparam int SLOT_W = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1;
   localparam int TBL_W  = (NUMBER_OF_TABLES > 1) ? $clog2(NUMBER_OF_TABLES) : 1;

   logic [NUMBER_OF_TABLES-1:0]                 tbl_hit;
   logic [NUMBER_OF_TABLES-1:0]                 tbl_free;
   logic [NUMBER_OF_TABLES-1:0][SLOT_W-1:0]     tbl_hit_slot;
   logic [NUMBER_OF_TABLES-1:0][SLOT_W-1:0]     tbl_free_slot;
   logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0] tbl_hit_data;

   logic                   hit_any;
   logic                   free_any;
   logic [TBL_W-1:0]       hit_tbl;
   logic [TBL_W-1:0]       free_tbl;
   logic                   wr_en;
   logic [TBL_W-1:0]       wr_tbl;
   logic [BW-1:0]          wr_content;
   logic [BUCKET_SIZE-1:0] wr_valid;
   status_t                nxt_status;
   logic [DATA_WIDTH-1:0]  nxt_data;
   logic                   accept;

   for (genvar t = 0; t < NUMBER_OF_TABLES; t++) begin : g_match
      bucket_slot_match #(
         .KEY_WIDTH   (KEY_WIDTH),
         .DATA_WIDTH  (DATA_WIDTH),
         .BUCKET_SIZE (BUCKET_SIZE)
      ) u_match (
         .key       (key_i),
         .content   (content_i[t]),
         .valid     (valid_i[t]),
         .hit       (tbl_hit[t]),
         .hit_slot  (tbl_hit_slot[t]),
         .free      (tbl_free[t]),
         .free_slot (tbl_free_slot[t]),
         .hit_data  (tbl_hit_data[t])
      );
   end

   assign op_ready_o = !result_valid_o || result_ready_i;
   assign accept     = op_valid_i && op_ready_o && clk_en;

   // Lowest table wins for both match and free search.
   always_comb begin
      hit_any  = 1'b0;
      hit_tbl  = '0;
      free_any = 1'b0;
      free_tbl = '0;
      for (int t = NUMBER_OF_TABLES - 1; t >= 0; t--) begin
         if (tbl_hit[t]) begin
            hit_any = 1'b1;
            hit_tbl = TBL_W'(t);
         end
         if (tbl_free[t]) begin
            free_any = 1'b1;
            free_tbl = TBL_W'(t);
         end
      end
   end

   // Rewritten bucket starts as a copy of the corrected input so untouched slots pass through.
   always_comb begin
      wr_en      = 1'b0;
      wr_tbl     = hit_tbl;
      wr_content = content_i[hit_tbl];
      wr_valid   = valid_i[hit_tbl];
      nxt_status = ST_BAD_OP;
      nxt_data   = '0;
      case (op_i)
         OP_LOOKUP: begin
            if (hit_any) begin
               nxt_status = ST_HIT;
               nxt_data   = tbl_hit_data[hit_tbl];
            end else begin
               nxt_status = ST_MISS;
            end
         end
         OP_INSERT: begin
            if (hit_any) begin
               wr_en      = 1'b1;
               wr_content[tbl_hit_slot[hit_tbl]*E +: DATA_WIDTH] = data_i;
               nxt_status = ST_UPDATED;
            end else if (free_any) begin
               wr_en      = 1'b1;
               wr_tbl     = free_tbl;
               wr_content = content_i[free_tbl];
               wr_valid   = valid_i[free_tbl];
               wr_content[tbl_free_slot[free_tbl]*E +: E] = {key_i, data_i};
               wr_valid[tbl_free_slot[free_tbl]]          = 1'b1;
               nxt_status = ST_INSERTED;
            end else begin
               nxt_status = ST_FULL;
            end
         end
         OP_DELETE: begin
            if (hit_any) begin
               wr_en      = 1'b1;
               wr_valid[tbl_hit_slot[hit_tbl]] = 1'b0;
               nxt_status = ST_DELETED;
            end else begin
               nxt_status = ST_MISS;
            end
         end
         default: nxt_status = ST_BAD_OP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_valid_o   <= 1'b0;
         result_status_o  <= '0;
         result_data_o    <= '0;
         wb_hash_adr_o    <= '0;
         wb_content_o     <= '0;
         wb_valid_o       <= '0;
         wb_updated_mem_o <= '0;
      end else if (clk_en) begin
         wb_updated_mem_o <= '0;
         if (accept) begin
            result_valid_o  <= 1'b1;
            result_status_o <= nxt_status;
            result_data_o   <= nxt_data;
            if (wr_en) begin
               wb_updated_mem_o[wr_tbl] <= 1'b1;
               wb_hash_adr_o[wr_tbl]    <= hash_adr_i[wr_tbl];
               wb_content_o[wr_tbl]     <= wr_content;
               wb_valid_o[wr_tbl]       <= wr_valid;
            end
         end else if (result_ready_i) begin
            result_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bucket_update_unit.sv
// tb/tb_bucket_update_unit.sv - self-checking bench for bucket_update_unit with a behavioural reference model
module tb_bucket_update_unit;
   import hash_pkg::*;

   localparam int NT = 4;
   localparam int KW = 2;
   localparam int DW = 4;
   localparam int AW = 2;
   localparam int E  = 6;

   logic clk = 1'b0;
   logic reset, clk_en, op_valid, op_ready, result_ready, result_valid;
   logic [1:0]              op;
   logic [KW-1:0]           key;
   logic [DW-1:0]           data;
   logic [NT-1:0][AW-1:0]   hash_adr, wb_adr;
   logic [NT-1:0][E-1:0]    content, wb_content;
   logic [NT-1:0][0:0]      valid, wb_valid;
   logic [NT-1:0]           wb_upd;
   logic [2:0]              status;
   logic [DW-1:0]           rdata;

   logic                    op_ready2, result_valid2;
   logic [NT-1:0][2*E-1:0]  content2, wb_content2;
   logic [NT-1:0][1:0]      valid2, wb_valid2;
   logic [NT-1:0][AW-1:0]   wb_adr2;
   logic [NT-1:0]           wb_upd2;
   logic [2:0]              status2;
   logic [DW-1:0]           rdata2;

   int checks   = 0;
   int failures = 0;

   logic [2:0]    exp_status;
   logic [DW-1:0] exp_data;
   int            exp_wr;
   logic [E-1:0]  exp_wc;
   logic          exp_wv;
   logic [AW-1:0] sh_adr     [NT];
   logic [E-1:0]  sh_content [NT];
   logic          sh_valid   [NT];

   always #5 clk = ~clk;

   bucket_update_unit dut (
      .clk(clk), .reset(reset), .clk_en(clk_en),
      .op_valid_i(op_valid), .op_ready_o(op_ready), .op_i(op), .key_i(key), .data_i(data),
      .hash_adr_i(hash_adr), .content_i(content), .valid_i(valid),
      .wb_hash_adr_o(wb_adr), .wb_content_o(wb_content), .wb_valid_o(wb_valid),
      .wb_updated_mem_o(wb_upd), .result_valid_o(result_valid), .result_ready_i(result_ready),
      .result_status_o(status), .result_data_o(rdata)
   );

   bucket_update_unit #(.BUCKET_SIZE(2)) dut2 (
      .clk(clk), .reset(reset), .clk_en(clk_en),
      .op_valid_i(op_valid), .op_ready_o(op_ready2), .op_i(op), .key_i(key), .data_i(data),
      .hash_adr_i(hash_adr), .content_i(content2), .valid_i(valid2),
      .wb_hash_adr_o(wb_adr2), .wb_content_o(wb_content2), .wb_valid_o(wb_valid2),
      .wb_updated_mem_o(wb_upd2), .result_valid_o(result_valid2), .result_ready_i(result_ready),
      .result_status_o(status2), .result_data_o(rdata2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: first valid key match / first free bucket in table order decides the outcome.
   task automatic model_op();
      int h, f;
      h = -1;
      f = -1;
      for (int t = 0; t < NT; t++) begin
         if (valid[t][0] && content[t][5:4] == key && h < 0) h = t;
         if (!valid[t][0] && f < 0) f = t;
      end
      exp_wr   = -1;
      exp_data = '0;
      exp_wc   = '0;
      exp_wv   = 1'b0;
      case (op)
         2'd0: if (h >= 0) begin exp_status = ST_HIT; exp_data = content[h][3:0]; end
               else exp_status = ST_MISS;
         2'd1: if (h >= 0) begin exp_wr = h; exp_wc = {key, data}; exp_wv = 1'b1; exp_status = ST_UPDATED; end
               else if (f >= 0) begin exp_wr = f; exp_wc = {key, data}; exp_wv = 1'b1; exp_status = ST_INSERTED; end
               else exp_status = ST_FULL;
         2'd2: if (h >= 0) begin exp_wr = h; exp_wc = content[h]; exp_wv = 1'b0; exp_status = ST_DELETED; end
               else exp_status = ST_MISS;
         default: exp_status = ST_BAD_OP;
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b1; op_valid = 1'b1; op = 2'd1; key = 2'd1; data = 4'd1;
      valid = '0; content = '0; clk_en = 1'b1; result_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_result_valid cyc=%0d got=%b exp=0", i, result_valid); end
         checks++;
         if (wb_upd !== 4'b0) begin failures++; $display("FAIL reset_wb_updated cyc=%0d got=%b exp=0000", i, wb_upd); end
      end
      checks++;
      if (status !== 3'd0 || rdata !== 4'd0) begin failures++; $display("FAIL reset_status_data got=%0d/%h exp=0/0", status, rdata); end
      reset = 1'b0; op_valid = 1'b0;
      tick();
   endtask

   task automatic test_bucket2();
      content2 = '0; valid2 = '0;
      content2[0] = {6'b11_1111, 6'b01_0011};
      valid2[0]   = 2'b01;
      op = 2'd1; key = 2'd2; data = 4'd7; op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      checks++;
      if (wb_upd2 !== 4'b0001) begin failures++; $display("FAIL b2_wb_updated got=%b exp=0001", wb_upd2); end
      checks++;
      if (wb_content2[0] !== {6'b10_0111, 6'b01_0011}) begin failures++; $display("FAIL b2_wb_content got=%b exp=100111010011", wb_content2[0]); end
      checks++;
      if (wb_valid2[0] !== 2'b11) begin failures++; $display("FAIL b2_wb_valid got=%b exp=11", wb_valid2[0]); end
      checks++;
      if (status2 !== ST_INSERTED) begin failures++; $display("FAIL b2_status got=%0d exp=%0d", status2, ST_INSERTED); end
      tick();
   endtask

   task automatic test_insert();
      hash_adr[0] = 2'd3; hash_adr[1] = 2'd1; hash_adr[2] = 2'd0; hash_adr[3] = 2'd2;
      valid = '0;
      for (int t = 0; t < NT; t++) content[t] = E'($urandom);
      op = 2'd1; key = 2'd2; data = 4'd5; op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      checks++;
      if (wb_upd !== 4'b0001) begin failures++; $display("FAIL ins_wb_updated got=%b exp=0001", wb_upd); end
      checks++;
      if (wb_adr[0] !== 2'd3) begin failures++; $display("FAIL ins_wb_adr got=%0d exp=3", wb_adr[0]); end
      checks++;
      if (wb_content[0] !== 6'b10_0101) begin failures++; $display("FAIL ins_wb_content got=%b exp=100101", wb_content[0]); end
      checks++;
      if (wb_valid[0] !== 1'b1) begin failures++; $display("FAIL ins_wb_valid got=%b exp=1", wb_valid[0]); end
      checks++;
      if (status !== ST_INSERTED || result_valid !== 1'b1) begin failures++; $display("FAIL ins_status got=%0d/%b exp=%0d/1", status, result_valid, ST_INSERTED); end
      tick();
      checks++;
      if (wb_upd !== 4'b0000) begin failures++; $display("FAIL ins_wb_drop got=%b exp=0000", wb_upd); end
      checks++;
      if (wb_content[0] !== 6'b10_0101) begin failures++; $display("FAIL ins_wb_hold got=%b exp=100101", wb_content[0]); end
   endtask

   task automatic setup_lookup();
      content[0] = 6'b00_0001; valid[0] = 1'b1;
      content[1] = 6'b01_0111; valid[1] = 1'b0;
      content[2] = 6'b01_1010; valid[2] = 1'b1;
      content[3] = 6'b01_1111; valid[3] = 1'b1;
   endtask

   task automatic test_lookup();
      setup_lookup();
      op = 2'd0; key = 2'd1; op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      checks++;
      if (status !== ST_HIT || rdata !== 4'hA) begin failures++; $display("FAIL lookup_hit got=%0d/%h exp=%0d/a", status, rdata, ST_HIT); end
      checks++;
      if (wb_upd !== 4'b0000) begin failures++; $display("FAIL lookup_no_wb got=%b exp=0000", wb_upd); end
      tick();
   endtask

   task automatic test_full_delete();
      content[0] = 6'b00_0001; content[1] = 6'b01_0010;
      content[2] = 6'b10_0011; content[3] = 6'b00_0100;
      valid = '1;
      op = 2'd1; key = 2'd3; data = 4'd9; op_valid = 1'b1;
      tick();
      checks++;
      if (status !== ST_FULL || rdata !== 4'd0) begin failures++; $display("FAIL full_status got=%0d/%h exp=%0d/0", status, rdata, ST_FULL); end
      checks++;
      if (wb_upd !== 4'b0000) begin failures++; $display("FAIL full_no_wb got=%b exp=0000", wb_upd); end
      content[3] = 6'b11_0110;
      op = 2'd2;
      tick();
      op_valid = 1'b0;
      checks++;
      if (status !== ST_DELETED) begin failures++; $display("FAIL del_status got=%0d exp=%0d", status, ST_DELETED); end
      checks++;
      if (wb_upd !== 4'b1000) begin failures++; $display("FAIL del_wb_updated got=%b exp=1000", wb_upd); end
      checks++;
      if (wb_valid[3] !== 1'b0 || wb_content[3] !== 6'b11_0110 || wb_adr[3] !== hash_adr[3]) begin
         failures++; $display("FAIL del_wb_bucket got=%b/%b/%0d exp=0/110110/%0d", wb_valid[3], wb_content[3], wb_adr[3], hash_adr[3]);
      end
      tick();
   endtask

   task automatic test_backpressure();
      setup_lookup();
      result_ready = 1'b0;
      op = 2'd0; key = 2'd1; op_valid = 1'b1;
      tick();
      op = 2'd2;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (op_ready !== 1'b0) begin failures++; $display("FAIL bp_op_ready cyc=%0d got=%b exp=0", i, op_ready); end
         checks++;
         if (result_valid !== 1'b1 || status !== ST_HIT || rdata !== 4'hA) begin
            failures++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h exp=1/%0d/a", i, result_valid, status, rdata, ST_HIT);
         end
         checks++;
         if (wb_upd !== 4'b0000) begin failures++; $display("FAIL bp_no_wb cyc=%0d got=%b exp=0000", i, wb_upd); end
         tick();
      end
      result_ready = 1'b1;
      #1;
      checks++;
      if (op_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_release got=%b exp=1", op_ready); end
      tick();
      op_valid = 1'b0;
      checks++;
      if (status !== ST_DELETED || wb_upd !== 4'b0100 || wb_valid[2] !== 1'b0) begin
         failures++; $display("FAIL bp_next_result got=%0d/%b/%b exp=%0d/0100/0", status, wb_upd, wb_valid[2], ST_DELETED);
      end
      tick();
   endtask

   task automatic test_clk_en();
      valid = '0;
      op = 2'd1; key = 2'd0; data = 4'd3; op_valid = 1'b1;
      tick();
      checks++;
      if (wb_upd !== 4'b0001) begin failures++; $display("FAIL ce_setup_wb got=%b exp=0001", wb_upd); end
      clk_en = 1'b0;
      op = 2'd0;
      content[0] = 6'b00_0011; valid[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (wb_upd !== 4'b0001 || result_valid !== 1'b1 || status !== ST_INSERTED) begin
            failures++; $display("FAIL ce_freeze cyc=%0d got=%b/%b/%0d exp=0001/1/%0d", i, wb_upd, result_valid, status, ST_INSERTED);
         end
      end
      clk_en = 1'b1;
      tick();
      op_valid = 1'b0;
      checks++;
      if (status !== ST_HIT || rdata !== 4'd3 || wb_upd !== 4'b0000) begin
         failures++; $display("FAIL ce_resume got=%0d/%h/%b exp=%0d/3/0000", status, rdata, wb_upd, ST_HIT);
      end
      tick();
   endtask

   task automatic test_reset_midop();
      valid = '0;
      op = 2'd1; key = 2'd1; data = 4'd6; op_valid = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (result_valid !== 1'b0 || status !== 3'd0 || rdata !== 4'd0) begin
         failures++; $display("FAIL midrst_result got=%b/%0d/%h exp=0/0/0", result_valid, status, rdata);
      end
      checks++;
      if (wb_upd !== '0 || wb_content !== '0 || wb_valid !== '0 || wb_adr !== '0) begin
         failures++; $display("FAIL midrst_wb got=%b/%h/%b/%h exp=all zero", wb_upd, wb_content, wb_valid, wb_adr);
      end
      reset = 1'b0; op_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [NT-1:0] exp_mask;
      reset = 1'b1; op_valid = 1'b0; clk_en = 1'b1; result_ready = 1'b1;
      tick();
      reset = 1'b0;
      for (int t = 0; t < NT; t++) begin sh_adr[t] = '0; sh_content[t] = '0; sh_valid[t] = 1'b0; end
      for (int n = 0; n < 300; n++) begin
         op       = 2'($urandom_range(0, 3));
         key      = KW'($urandom);
         data     = DW'($urandom);
         op_valid = ($urandom_range(0, 3) != 0);
         for (int t = 0; t < NT; t++) begin
            hash_adr[t] = AW'($urandom);
            content[t]  = E'($urandom);
            valid[t]    = 1'($urandom);
         end
         model_op();
         exp_mask = '0;
         if (op_valid && exp_wr >= 0) begin
            exp_mask[exp_wr]   = 1'b1;
            sh_adr[exp_wr]     = hash_adr[exp_wr];
            sh_content[exp_wr] = exp_wc;
            sh_valid[exp_wr]   = exp_wv;
         end
         tick();
         checks++;
         if (result_valid !== op_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, result_valid, op_valid); end
         if (op_valid) begin
            checks++;
            if (status !== exp_status || rdata !== exp_data) begin
               failures++; $display("FAIL rnd_result n=%0d op=%0d got=%0d/%h exp=%0d/%h", n, op, status, rdata, exp_status, exp_data);
            end
         end
         checks++;
         if (wb_upd !== exp_mask) begin failures++; $display("FAIL rnd_wb_mask n=%0d got=%b exp=%b", n, wb_upd, exp_mask); end
         for (int t = 0; t < NT; t++) begin
            checks++;
            if (wb_adr[t] !== sh_adr[t] || wb_content[t] !== sh_content[t] || wb_valid[t][0] !== sh_valid[t]) begin
               failures++; $display("FAIL rnd_wb_bucket n=%0d t=%0d got=%0d/%b/%b exp=%0d/%b/%b", n, t,
                                    wb_adr[t], wb_content[t], wb_valid[t], sh_adr[t], sh_content[t], sh_valid[t]);
            end
         end
      end
      op_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clk_en = 1'b1; op_valid = 1'b0; result_ready = 1'b1;
      op = '0; key = '0; data = '0; hash_adr = '0; content = '0; valid = '0;
      content2 = '0; valid2 = '0;
      test_reset();
      test_bucket2();
      test_insert();
      test_lookup();
      test_full_delete();
      test_backpressure();
      test_clk_en();
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
